uart_rx: RTL and testbench

- UART receiver: the receive-side counterpart to the transmit path driven by uart_baudgen.
- Recovers 8N1 frames from the asynchronous serial line `rx` and sets its own timing with an internal oversampling tick that is re-phased on each start bit.
- Delivers each byte on a valid/ready stream and flags framing errors and overruns.
- Sits between the board UART pin and the host command/timestamp readout logic.

---
 rtl/uart_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with start-bit re-phased oversampling tick and
//            a valid/ready byte output that reports framing errors and overruns.
// Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 1_000_000,
    parameter int OVERSAMPLE = 10,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int DIV  = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int HALF = OVERSAMPLE / 2;
    localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW   = $clog2(OVERSAMPLE);
    localparam int IW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [DW-1:0] c_DIV_LAST  = DW'(DIV - 1);
    localparam logic [TW-1:0] c_HALF_LAST = TW'(HALF - 1);
    localparam logic [TW-1:0] c_OS_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] c_BIT_LAST  = IW'(DATA_BITS - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_rx: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 1");
        end
        if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
            $error("uart_rx: OVERSAMPLE must be even and at least 4");
        end
    endgenerate

    logic                 r_sync;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    logic [1:0]           r_state;
    logic [DW-1:0]        r_div_cnt;
    logic [TW-1:0]        r_tick_cnt;
    logic [IW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_done;
    logic                 r_stop_bad;
    logic [DATA_BITS-1:0] r_m_data;
    logic                 r_m_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_tick;
    logic w_start;

    assign w_tick  = (r_div_cnt == c_DIV_LAST);
    // Only a genuine high-to-low transition arms a frame; a stuck-low line cannot.
    assign w_start = (r_state == c_IDLE) && r_rx_prev && !r_rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_state    <= c_IDLE;
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_done     <= 1'b0;
            r_stop_bad <= 1'b0;
        end else begin
            r_sync     <= rx;
            r_rx_s     <= r_sync;
            r_rx_prev  <= r_rx_s;
            r_done     <= 1'b0;
            r_stop_bad <= 1'b0;

            if (w_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + DW'(1);
            end

            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_state    <= c_START;
                        r_div_cnt  <= '0;
                        r_tick_cnt <= '0;
                        r_bit_idx  <= '0;
                    end
                end
                c_START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_HALF_LAST) begin
                            r_tick_cnt <= '0;
                            r_bit_idx  <= '0;
                            r_state    <= r_rx_s ? c_IDLE : c_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
                c_DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_OS_LAST) begin
                            r_tick_cnt         <= '0;
                            r_shift[r_bit_idx] <= r_rx_s;
                            if (r_bit_idx == c_BIT_LAST) begin
                                r_state <= c_STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx + IW'(1);
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
                c_STOP: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_OS_LAST) begin
                            r_tick_cnt <= '0;
                            r_state    <= c_IDLE;
                            r_done     <= r_rx_s;
                            r_stop_bad <= !r_rx_s;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Output holding register: a byte arriving while the previous one is
    // still unconsumed is dropped and reported instead of overwriting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= r_stop_bad;
            r_overrun   <= 1'b0;
            if (r_done) begin
                if (!r_m_valid || m_ready) begin
                    r_m_data  <= r_shift;
                    r_m_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_data    = r_m_data;
    assign m_valid   = r_m_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx driving 8N1 frames on rx.
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

    localparam int BIT_CLKS = 100;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       rx      = 1'b1;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .CLK_HZ    (100_000_000),
        .BAUD      (1_000_000),
        .OVERSAMPLE(10),
        .DATA_BITS (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Free-running observation counters; tests work on deltas.
    int         cyc      = 0;
    int         n_acc    = 0;
    int         n_ferr   = 0;
    int         n_ovr    = 0;
    int         n_rise   = 0;
    int         n_vhigh  = 0;
    int         rise_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] acc_mem [0:1023];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            acc_mem[n_acc[9:0]] <= m_data;
            n_acc <= n_acc + 1;
        end
        if (m_valid) n_vhigh <= n_vhigh + 1;
        if (m_valid && !prev_valid) begin
            rise_cyc <= cyc;
            n_rise   <= n_rise + 1;
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (overrun) n_ovr <= n_ovr + 1;
        prev_valid <= m_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) align();
    endtask

    // Drives one frame; rx is left at the stop-bit level afterwards.
    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit,
                              output int t_fall);
        align();
        t_fall = cyc;
        rx = 1'b0;
        repeat (per) align();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (per) align();
        end
        rx = stop_bit;
        repeat (per) align();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) align();
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", m_data); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", overrun); end
        rst = 1'b0;
        idle(20);
    endtask

    task automatic test_single();
        int tf, a0, r0, v0, f0, o0, lat;
        a0 = n_acc; r0 = n_rise; v0 = n_vhigh; f0 = n_ferr; o0 = n_ovr;
        m_ready = 1'b1;
        send_frame(8'hA5, BIT_CLKS, 1'b1, tf);
        idle(20);
        lat = rise_cyc - tf;
        n_checks++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL single_count: got %0d bytes want 1", n_acc - a0); end
        n_checks++; if (acc_mem[a0[9:0]] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", acc_mem[a0[9:0]]); end
        n_checks++; if (n_rise - r0 !== 1 || lat < 952 || lat > 955) begin n_fail++; $display("FAIL single_latency: got %0d cycles want 952..955", lat); end
        n_checks++; if (n_vhigh - v0 !== 1) begin n_fail++; $display("FAIL single_width: got %0d cycles high want 1", n_vhigh - v0); end
        n_checks++; if (n_ferr - f0 !== 0 || n_ovr - o0 !== 0) begin n_fail++; $display("FAIL single_flags: got ferr=%0d ovr=%0d want 0 0", n_ferr - f0, n_ovr - o0); end
    endtask

    task automatic test_random_bytes();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int tf, a0;
        a0 = n_acc;
        m_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, BIT_CLKS, 1'b1, tf);
            idle($urandom_range(0, 40));
        end
        idle(20);
        n_checks++; if (n_acc - a0 !== exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d want %0d", n_acc - a0, exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (acc_mem[(a0 + k) % 1024] !== exp_q[k]) begin
                n_fail++; $display("FAIL random_data[%0d]: got %h want %h", k, acc_mem[(a0 + k) % 1024], exp_q[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic       held;
        logic [7:0] held_b;
        int         exp_ovr, tf, a0, o0;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
        held = 1'b0; held_b = 8'h00; exp_ovr = 0;
        a0 = n_acc; o0 = n_ovr;
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!held) begin held = 1'b1; held_b = bytes[k]; end
            else exp_ovr++;
            send_frame(bytes[k], BIT_CLKS, 1'b1, tf);
        end
        idle(20);
        n_checks++; if (m_valid !== held) begin n_fail++; $display("FAIL b2b_valid: got %b want %b", m_valid, held); end
        n_checks++; if (m_data !== held_b) begin n_fail++; $display("FAIL b2b_data: got %h want %h", m_data, held_b); end
        n_checks++; if (n_ovr - o0 !== exp_ovr) begin n_fail++; $display("FAIL b2b_overrun: got %0d pulses want %0d", n_ovr - o0, exp_ovr); end
        m_ready = 1'b1;
        align();
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_clear: got valid %b want 0", m_valid); end
        n_checks++; if (n_acc - a0 !== 1 || acc_mem[a0[9:0]] !== held_b) begin n_fail++; $display("FAIL b2b_accept: got %0d bytes first %h want 1 byte %h", n_acc - a0, acc_mem[a0[9:0]], held_b); end
        idle(10);
    endtask

    task automatic test_glitch();
        int tf, a0, f0, r0;
        a0 = n_acc; f0 = n_ferr; r0 = n_rise;
        m_ready = 1'b1;
        align();
        rx = 1'b0;
        repeat (30) align();
        idle(200);
        n_checks++; if (n_rise - r0 !== 0 || n_ferr - f0 !== 0) begin n_fail++; $display("FAIL glitch_reject: got valid=%0d ferr=%0d want 0 0", n_rise - r0, n_ferr - f0); end
        send_frame(8'h5A, BIT_CLKS, 1'b1, tf);
        idle(20);
        n_checks++; if (n_acc - a0 !== 1 || acc_mem[a0[9:0]] !== 8'h5A) begin n_fail++; $display("FAIL glitch_next: got %0d bytes first %h want 1 byte 5a", n_acc - a0, acc_mem[a0[9:0]]); end
    endtask

    task automatic test_frame_err();
        int tf, a0, f0, r0, o0;
        a0 = n_acc; f0 = n_ferr; r0 = n_rise; o0 = n_ovr;
        m_ready = 1'b1;
        send_frame(8'h81, BIT_CLKS, 1'b0, tf);
        repeat (2000) align();
        idle(50);
        n_checks++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d pulses want 1", n_ferr - f0); end
        n_checks++; if (n_rise - r0 !== 0 || n_ovr - o0 !== 0) begin n_fail++; $display("FAIL ferr_nobyte: got valid=%0d ovr=%0d want 0 0", n_rise - r0, n_ovr - o0); end
        send_frame(8'h42, BIT_CLKS, 1'b1, tf);
        idle(20);
        n_checks++; if (n_acc - a0 !== 1 || acc_mem[a0[9:0]] !== 8'h42) begin n_fail++; $display("FAIL ferr_next: got %0d bytes first %h want 1 byte 42", n_acc - a0, acc_mem[a0[9:0]]); end
    endtask

    task automatic test_tolerance();
        int         pers [6];
        logic [7:0] exp_b [6];
        int         tf, a0;
        pers[0] = 97;  exp_b[0] = 8'h55;
        pers[1] = 103; exp_b[1] = 8'h55;
        for (int k = 2; k < 6; k++) begin
            pers[k]  = $urandom_range(97, 103);
            exp_b[k] = 8'($urandom);
        end
        m_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a0 = n_acc;
            send_frame(exp_b[k], pers[k], 1'b1, tf);
            idle(30);
            n_checks++;
            if (n_acc - a0 !== 1 || acc_mem[a0[9:0]] !== exp_b[k]) begin
                n_fail++; $display("FAIL tol_%0dclk: got %0d bytes first %h want 1 byte %h", pers[k], n_acc - a0, acc_mem[a0[9:0]], exp_b[k]);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [7:0] c3;
        int tf, a0, r0, f0;
        c3 = 8'hC3;
        m_ready = 1'b0;
        send_frame(8'($urandom), BIT_CLKS, 1'b1, tf);
        idle(20);
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pending: got valid %b want 1", m_valid); end
        align();
        rx = 1'b0;
        repeat (BIT_CLKS) align();
        for (int i = 0; i < 4; i++) begin
            rx = c3[i];
            repeat (BIT_CLKS) align();
        end
        rx = c3[4];
        repeat (BIT_CLKS / 2) align();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) align();
        n_checks++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin n_fail++; $display("FAIL rst_clear: got valid=%b data=%h want 0 00", m_valid, m_data); end
        rst = 1'b0;
        m_ready = 1'b1;
        a0 = n_acc; r0 = n_rise; f0 = n_ferr;
        idle(1200);
        n_checks++; if (n_rise - r0 !== 0 || n_ferr - f0 !== 0) begin n_fail++; $display("FAIL rst_abort: got valid=%0d ferr=%0d want 0 0", n_rise - r0, n_ferr - f0); end
        send_frame(8'h18, BIT_CLKS, 1'b1, tf);
        idle(20);
        n_checks++; if (n_acc - a0 !== 1 || acc_mem[a0[9:0]] !== 8'h18) begin n_fail++; $display("FAIL rst_next: got %0d bytes first %h want 1 byte 18", n_acc - a0, acc_mem[a0[9:0]]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_random_bytes();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_tolerance();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
